// File: rtl/stream_divider_if.sv
// Stream handshake bundle for stream_divider.
// slave: divider side; master: producer/consumer side.
interface stream_divider_if;
  logic        i_ready;
  logic        i_valid;
  logic [31:0] i_payload_a;
  logic [15:0] i_payload_b;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_payload_quotient;
  logic [15:0] o_payload_remainder;
  logic        o_div_by_zero;

  modport master (
    input  i_ready,
    output i_valid,
    output i_payload_a,
    output i_payload_b,
    input  o_valid,
    output o_ready,
    input  o_payload_quotient,
    input  o_payload_remainder,
    input  o_div_by_zero
  );

  modport slave (
    output i_ready,
    input  i_valid,
    input  i_payload_a,
    input  i_payload_b,
    output o_valid,
    input  o_ready,
    output o_payload_quotient,
    output o_payload_remainder,
    output o_div_by_zero
  );
endinterface

// File: rtl/stream_divider.sv
// 32/16 unsigned restoring divider, one quotient bit per cycle.
// Ports: clk, reset (sync, active-high), bus (stream_divider_if.slave).
// `STREAM_DIVIDER_DIV0_FAST_EN: zero divisor finishes after one edge.
module stream_divider (
  input  logic            clk,
  input  logic            reset,
  stream_divider_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] a_q;
  logic [15:0] b_q;
  logic [15:0] r_q;
  logic [31:0] q_q;
  logic [4:0]  cnt_q;
  logic        dz_q;

  logic [16:0] rp;
  logic        ge;
  logic        fast_dz;
  logic        last_step;

  // Shifted partial remainder; the stored R always fits
  // 16 bits, the 17th bit only exists after the shift.
  assign rp = {r_q, a_q[cnt_q]};
  assign ge = rp >= {1'b0, b_q};

`ifdef STREAM_DIVIDER_DIV0_FAST_EN
  assign fast_dz = dz_q;
`else
  assign fast_dz = 1'b0;
`endif

  assign last_step = (cnt_q == 5'd0) || fast_dz;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.i_valid) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.o_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      q_q   <= '0;
      cnt_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.i_valid) begin
            a_q   <= bus.i_payload_a;
            b_q   <= bus.i_payload_b;
            dz_q  <= bus.i_payload_b == 16'd0;
            r_q   <= '0;
            q_q   <= '0;
            cnt_q <= 5'd31;
          end
        end
        BUSY: begin
          if (fast_dz) begin
            // Same values the full iteration yields for b=0.
            q_q <= '1;
            r_q <= a_q[15:0];
          end else begin
            // Low 16 bits of rp-b equal rp[15:0]-b mod 2^16.
            r_q        <= ge ? (rp[15:0] - b_q) : rp[15:0];
            q_q[cnt_q] <= ge;
            cnt_q      <= cnt_q - 5'd1;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Payloads are gated so they read zero whenever no
  // result is being offered.
  always_comb begin
    bus.i_ready             = 1'b0;
    bus.o_valid             = 1'b0;
    bus.o_payload_quotient  = '0;
    bus.o_payload_remainder = '0;
    bus.o_div_by_zero       = 1'b0;
    unique case (state)
      IDLE: begin
        bus.i_ready = 1'b1;
      end
      DONE: begin
        bus.o_valid             = 1'b1;
        bus.o_payload_quotient  = q_q;
        bus.o_payload_remainder = r_q;
        bus.o_div_by_zero       = dz_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_stream_divider.sv
// Scoreboard bench for stream_divider.
// Reference model uses plain / and % on accepted operands.
module tb_stream_divider;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stream_divider_if ifc();

  stream_divider dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  typedef struct {
    logic [31:0] q;
    logic [15:0] r;
    logic        dz;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic prev_v = 1'b0;
  int   last_rise = -1;
  bit   chk_ii = 1'b0;
  bit   rnd_run = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d",
               name, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a,
                                 input logic [15:0] b,
                                 input int acc);
    exp_t e;
    logic [31:0] rem;
    e.acc = acc;
    if (b == 16'd0) begin
      e.q  = 32'hFFFF_FFFF;
      e.r  = a[15:0];
      e.dz = 1'b1;
`ifdef STREAM_DIVIDER_DIV0_FAST_EN
      e.lat = 1;
`else
      e.lat = 32;
`endif
    end else begin
      e.q   = a / {16'd0, b};
      rem   = a % {16'd0, b};
      e.r   = rem[15:0];
      e.dz  = 1'b0;
      e.lat = 32;
    end
    return e;
  endfunction

  // Stimulus side of the scoreboard: record every accepted op.
  always @(negedge clk) begin
    if (!reset && ifc.i_valid && ifc.i_ready) begin
      sb.push_back(model(ifc.i_payload_a,
                         ifc.i_payload_b, cyc + 1));
    end
  end

  // Monitor: latency on o_valid rise, payload on transfer.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (ifc.o_valid && !prev_v) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", sb.size(), 1);
        end else begin
          check("latency", cyc - sb[0].acc, sb[0].lat);
        end
        if (chk_ii && last_rise >= 0) begin
          check("init_interval", cyc - last_rise, 34);
        end
        last_rise = cyc;
      end
      if (ifc.o_valid && ifc.o_ready && sb.size() > 0) begin
        e = sb.pop_front();
        check("quotient", ifc.o_payload_quotient, e.q);
        check("remainder", ifc.o_payload_remainder, e.r);
        check("div_by_zero", ifc.o_div_by_zero, e.dz);
      end
      prev_v = ifc.o_valid;
    end
  end

  task automatic send(input logic [31:0] a,
                      input logic [15:0] b,
                      input bit drop);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    ifc.i_valid     = 1'b1;
    ifc.i_payload_a = a;
    ifc.i_payload_b = b;
    do begin
      @(negedge clk);
      ok = ifc.i_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 300);
    if (!ok) check("accept_timeout", n, 0);
    if (drop) ifc.i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Single op, checks i_ready stays low until the result.
  task automatic run_one(input logic [31:0] a,
                         input logic [15:0] b);
    int hi;
    int n;
    hi = 0;
    n = 0;
    send(a, b, 1'b1);
    while (!ifc.o_valid && n < 40) begin
      @(negedge clk);
      if (!ifc.o_valid && ifc.i_ready) hi++;
      n++;
    end
    check("busy_i_ready", hi, 0);
    drain();
  endtask

  initial begin
    logic [31:0] q0;
    logic [15:0] r0;
    logic [15:0] b;
    int n;

    ifc.i_valid     = 1'b0;
    ifc.i_payload_a = '0;
    ifc.i_payload_b = '0;
    ifc.o_ready     = 1'b1;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_i_ready", ifc.i_ready, 1);
    check("rst_o_valid", ifc.o_valid, 0);
    check("rst_q", ifc.o_payload_quotient, 0);
    check("rst_r", ifc.o_payload_remainder, 0);
    check("rst_dz", ifc.o_div_by_zero, 0);
    @(posedge clk);
    #1;

    run_one(32'd100, 16'd7);
    run_one(32'hFFFF_FFFF, 16'hFFFF);
    run_one(32'd3, 16'd10);
    run_one(32'h1234_5678, 16'd1);
    run_one(32'h0001_ABCD, 16'd0);

    // Backpressure with input churn while busy.
    ifc.o_ready = 1'b0;
    send(32'd1000, 16'd3, 1'b1);
    n = 0;
    while (!ifc.o_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", ifc.o_valid, 1);
    q0 = ifc.o_payload_quotient;
    r0 = ifc.o_payload_remainder;
    check("bp_q_direct", q0, 32'd333);
    check("bp_r_direct", r0, 16'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      ifc.i_valid     = 1'b1;
      ifc.i_payload_a = $urandom;
      ifc.i_payload_b = 16'($urandom);
      @(negedge clk);
      check("bp_hold_v", ifc.o_valid, 1);
      check("bp_hold_q", ifc.o_payload_quotient, q0);
      check("bp_hold_r", ifc.o_payload_remainder, r0);
      check("bp_i_ready", ifc.i_ready, 0);
    end
    @(posedge clk);
    #1;
    ifc.i_valid = 1'b0;
    ifc.o_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_after_ready", ifc.i_ready, 1);
    check("bp_after_valid", ifc.o_valid, 0);
    check("bp_sb_empty", sb.size(), 0);
    @(posedge clk);
    #1;

    // Reset in the middle of BUSY.
    send(32'd12345, 16'd77, 1'b1);
    repeat (15) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", ifc.o_valid, 0);
    check("mid_rst_q", ifc.o_payload_quotient, 0);
    check("mid_rst_r", ifc.o_payload_remainder, 0);
    check("mid_rst_dz", ifc.o_div_by_zero, 0);
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", ifc.i_ready, 1);
    @(posedge clk);
    #1;
    run_one(32'd50, 16'd6);

    // Back-to-back with i_valid held high.
    chk_ii = 1'b1;
    last_rise = -1;
    for (int i = 0; i < 3; i++) begin
      b = 16'($urandom_range(1, 65535));
      send($urandom, b, i == 2);
    end
    drain();
    chk_ii = 1'b0;

    // Random traffic with random output backpressure.
    rnd_run = 1'b1;
    fork
      begin
        while (rnd_run) begin
          @(posedge clk);
          #1;
          ifc.o_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 5))
        0: b = 16'd0;
        1: b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      send($urandom, b, 1'b1);
    end
    drain();
    rnd_run = 1'b0;
    @(posedge clk);
    #1;
    ifc.o_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
